pe_issue_ctrl: RTL
==================

Name: pe_issue_ctrl

Overview:
Issue/writeback controller that sits directly upstream of pe_core_single and pe_regfile.
- Accepts 32-bit instructions over a valid/ready handshake and reads source operands from pe_regfile.
- Stalls on register hazards, then drives opcode/op1/op2/op3/valid_in into pe_core_single.
- Captures result_out/result_valid and writes it back through the pe_regfile write port.
- In-order only; tracks in-flight destinations with a tag FIFO and a per-register scoreboard.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- NREG, 32, number of architectural registers
- TAG_DEPTH, 4, maximum in-flight instructions (power of 2, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_in  in  32  instruction: [31:25] major, [24:20] func, [19:15] rs1, [14:10] rs2, [9:5] imm5, [4:0] rd
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid&ready
- rf_rd_addr1  out  ADDR_W  regfile read address A (combinational read)
- rf_rd_addr2  out  ADDR_W  regfile read address B
- rf_rd_data1  in  DATA_W  read data A
- rf_rd_data2  in  DATA_W  read data B
- pe_opcode  out  32  instruction forwarded to core
- pe_op1  out  DATA_W  operand 1
- pe_op2  out  DATA_W  operand 2
- pe_op3  out  DATA_W  zero-extended imm5
- pe_valid  out  1  one-cycle issue strobe
- pe_result  in  DATA_W  core result
- pe_result_valid  in  1  core result strobe
- rf_wr_addr  out  ADDR_W  writeback address
- rf_wr_data  out  DATA_W  writeback data
- rf_wr_en  out  1  writeback strobe
- busy  out  1  IR valid or tag FIFO non-empty
- wb_err  out  1  sticky: result received with no tag outstanding

Behaviour:
- Reset: IR empty, scoreboard all 0, tag FIFO empty, wb_err=0, pe_valid=0, rf_wr_en=0, all data/address outputs 0, instr_ready=1 in the first cycle after reset.
- Reset mid-operation discards IR, scoreboard and tags.
- IR: single instruction register. instr_ready = !ir_valid | issue. Sustained throughput is 1 instruction/cycle when there are no stalls.
- Read: rf_rd_addr1/2 = IR rs1/rs2 combinationally.
- Operand value:
  - rs==0 gives 0.
  - Else, if rf_wr_en and rf_wr_addr==rs, gives rf_wr_data (bypass).
  - Else gives rf_rd_data.
- Stall conditions: stall = ir_valid & (pend[rs1] | pend[rs2] | pend[rd] | tag_full). pend[0] is always 0.
- Issue: issue = ir_valid & !stall. On the issue edge:
  - pe_opcode/op1/op2/op3 are registered and pe_valid=1 for exactly the next cycle, then 0.
  - If rd≠0: pend[rd] set and rd pushed to tag FIFO.
  - If rd==0: pushes a null tag (writeback suppressed).
- Latency: instruction accepted on edge E; pe_valid high in cycle after edge E+1 when unstalled.
- Writeback, on a cycle with pe_result_valid and tag FIFO non-empty:
  - Pop tag at that edge.
  - Register rf_wr_addr=tag, rf_wr_data=pe_result, rf_wr_en=1 (0 for null tag) for one cycle.
  - Clear pend[tag] at the same edge.
- Writeback with empty FIFO: pe_result_valid with FIFO empty is dropped and sets wb_err (cleared only by rst).
- Simultaneous pop and push: allowed in the same cycle; FIFO count unchanged.
- Simultaneous set/clear of the same pend bit: set wins. This cannot occur while the WAW stall is in place, but is defined anyway.
- Full/empty: tag_full when count==TAG_DEPTH. Pointers wrap modulo TAG_DEPTH.
- The core is assumed in-order; results pair with tags strictly FIFO.

Optional Feature:
- Macro PE_ISSUE_PERF_EN.
- When defined, adds outputs:
  - perf_issued, 32b: count of issue cycles.
  - perf_stall_haz, 32b: cycles with ir_valid & hazard.
  - perf_stall_full, 32b: cycles with ir_valid & tag_full & !hazard.
  - All three counters saturate at 0xFFFFFFFF, clear on rst, and carry no functional effect.
- When not defined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- ADD: bench regfile R1=10, R2=20. Send {0000001,00001,rs1=1,rs2=2,imm=0,rd=3}. Expect pe_valid 2 cycles after accept with op1=10, op2=20. Core returns 30. Expect rf_wr_en, addr=3, data=30 one cycle later; busy falls.
- RAW: ADD rd=3 (50+25) back-to-back with SUB {0000001,00010,rs1=3,rs2=4,rd=5}, R4=10. Expect SUB held and instr_ready=0 until writeback. Expect SUB issued the cycle after rf_wr_en with op1=75 (bypass), op2=10.
- WAW: two ADDs to rd=3 back-to-back. Expect second held until first writeback; no lost or duplicated rf_wr_en.
- Tag full: core model withholds results. Expect exactly 4 issues, then instr_ready=0. Release one result; expect one more issue in the following cycles.
- Zero register: rs1=0 with R0 garbage on rf_rd_data1 gives op1=0. rd=0 gives no rf_wr_en and no stall on later rd=0.
- Reset mid-flight: assert rst with 2 tags outstanding. Expect all outputs at reset values. A subsequent pe_result_valid sets wb_err=1 and causes no rf_wr_en.

Source files
------------

// File: rtl/pe_issue_ctrl.sv
// In-order issue/writeback controller between pe_regfile and pe_core_single.
// Define PE_ISSUE_PERF_EN to add saturating issue/stall performance counters.
module pe_issue_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NREG      = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [31:0]       pe_opcode,
  output logic [DATA_W-1:0] pe_op1,
  output logic [DATA_W-1:0] pe_op2,
  output logic [DATA_W-1:0] pe_op3,
  output logic              pe_valid,
  input  logic [DATA_W-1:0] pe_result,
  input  logic              pe_result_valid,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              busy,
  output logic              wb_err
`ifdef PE_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall_haz,
  output logic [31:0]       perf_stall_full
`endif
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic              r_ir_valid;
  logic [31:0]       r_ir;
  logic [NREG-1:0]   r_pend;
  logic [NREG-1:0]   w_pend_nxt;
  logic [ADDR_W-1:0] r_tag_mem [TAG_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [31:0]       r_pe_opcode;
  logic [DATA_W-1:0] r_pe_op1;
  logic [DATA_W-1:0] r_pe_op2;
  logic [DATA_W-1:0] r_pe_op3;
  logic              r_pe_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic              r_wb_err;

  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_tag;
  logic [4:0]        w_imm;
  logic              w_full;
  logic              w_empty;
  logic              w_hazard;
  logic              w_stall;
  logic              w_issue;
  logic              w_accept;
  logic              w_pop;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  assign w_rs1 = r_ir[15 +: ADDR_W];
  assign w_rs2 = r_ir[10 +: ADDR_W];
  assign w_rd  = r_ir[0 +: ADDR_W];
  assign w_imm = r_ir[9:5];
  assign w_tag = r_tag_mem[r_rd_ptr];

  assign w_full   = (r_count == (PW+1)'(TAG_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_hazard = r_pend[w_rs1] | r_pend[w_rs2] | r_pend[w_rd];
  assign w_stall  = r_ir_valid & (w_hazard | w_full);
  assign w_issue  = r_ir_valid & ~w_stall;
  assign w_accept = instr_valid & instr_ready;
  assign w_pop    = pe_result_valid & ~w_empty;

  // The result being written this cycle is not yet visible in the regfile.
  assign w_op1 = (w_rs1 == '0) ? '0 :
                 (r_wr_en && r_wr_addr == w_rs1) ? r_wr_data : rf_rd_data1;
  assign w_op2 = (w_rs2 == '0) ? '0 :
                 (r_wr_en && r_wr_addr == w_rs2) ? r_wr_data : rf_rd_data2;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop) w_pend_nxt[w_tag] = 1'b0;
    if (w_issue) w_pend_nxt[w_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_valid  <= 1'b0;
      r_ir        <= '0;
      r_pend      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pe_opcode <= '0;
      r_pe_op1    <= '0;
      r_pe_op2    <= '0;
      r_pe_op3    <= '0;
      r_pe_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_wb_err    <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_ir_valid <= 1'b1;
        r_ir       <= instr_in;
      end else if (w_issue) begin
        r_ir_valid <= 1'b0;
      end
      r_pend <= w_pend_nxt;
      if (w_issue) begin
        r_tag_mem[r_wr_ptr] <= w_rd;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pe_valid <= w_issue;
      if (w_issue) begin
        r_pe_opcode <= r_ir;
        r_pe_op1    <= w_op1;
        r_pe_op2    <= w_op2;
        r_pe_op3    <= {{(DATA_W-5){1'b0}}, w_imm};
      end
      // A null tag (rd==0) still pairs with its result but writes nothing.
      r_wr_en <= w_pop & (w_tag != '0);
      if (w_pop) begin
        r_wr_addr <= w_tag;
        r_wr_data <= pe_result;
      end
      if (pe_result_valid && w_empty) r_wb_err <= 1'b1;
    end
  end

  assign instr_ready = ~r_ir_valid | w_issue;
  assign rf_rd_addr1 = w_rs1;
  assign rf_rd_addr2 = w_rs2;
  assign pe_opcode   = r_pe_opcode;
  assign pe_op1      = r_pe_op1;
  assign pe_op2      = r_pe_op2;
  assign pe_op3      = r_pe_op3;
  assign pe_valid    = r_pe_valid;
  assign rf_wr_addr  = r_wr_addr;
  assign rf_wr_data  = r_wr_data;
  assign rf_wr_en    = r_wr_en;
  assign busy        = r_ir_valid | ~w_empty;
  assign wb_err      = r_wb_err;

`ifdef PE_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_haz;
  logic [31:0] r_perf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued <= '0;
      r_perf_haz    <= '0;
      r_perf_full   <= '0;
    end else begin
      if (w_issue && r_perf_issued != '1)
        r_perf_issued <= r_perf_issued + 1'b1;
      if (r_ir_valid && w_hazard && r_perf_haz != '1)
        r_perf_haz <= r_perf_haz + 1'b1;
      if (r_ir_valid && w_full && !w_hazard && r_perf_full != '1)
        r_perf_full <= r_perf_full + 1'b1;
    end
  end

  assign perf_issued     = r_perf_issued;
  assign perf_stall_haz  = r_perf_haz;
  assign perf_stall_full = r_perf_full;
`endif

endmodule
